uart_rx_ctrl: RTL

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit sides.
//   DEF_CLK_FREQ / DEF_BAUD : default system clock (Hz) and line rate (bit/s)
//   FRAME_BITS              : data bits per 8N1 frame
//   uart_state_e            : receiver/transmitter frame state
package uart_pkg;

   localparam int unsigned DEF_CLK_FREQ = 100_000_000;
   localparam int unsigned DEF_BAUD     = 19_200;
   localparam int unsigned FRAME_BITS   = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset, both flops load RST_VAL
//   d      : asynchronous input
//   q      : synchronized output (two clk cycles of latency)
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver.
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   uart_rx   : asynchronous serial line, idle high
//   data      : last correctly framed byte
//   valid     : one-cycle pulse when data is updated
//   frame_err : one-cycle pulse when the stop bit is sampled low
//   busy      : high whenever the receiver is not idle
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
   parameter int unsigned BAUD     = DEF_BAUD
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned BIT_TICKS  = CLK_FREQ / BAUD;
   localparam int unsigned HALF_TICKS = BIT_TICKS / 2;
   localparam int unsigned CW         = $clog2(BIT_TICKS);
   localparam int unsigned IW         = $clog2(FRAME_BITS);

   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_TICKS - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_TICKS - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(FRAME_BITS - 1);

   generate
      if (BIT_TICKS < 4) begin : g_bad_ratio
         $error("uart_rx_ctrl: CLK_FREQ/BAUD must be at least 4");
      end
   endgenerate

   logic rx_s;

   uart_state_e          state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [FRAME_BITS-1:0] shreg_q, shreg_d;
   logic [FRAME_BITS-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  ferr_q, ferr_d;

   sync_2ff #(
      .RST_VAL(1'b1)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (uart_rx),
      .q    (rx_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   // The counter is cleared on every bit sample and on every state change,
   // so it never runs past BIT_TICKS-1 and cannot wrap.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) begin
               state_d = START;
            end
         end

         // Sample the middle of the start bit; a high line here was a glitch.
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d = DATA;
                  idx_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d          = '0;
               shreg_d[idx_q] = rx_s;
               if (idx_q == IDX_LAST) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  data_d  = shreg_q;
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         // A line held low after a bad stop bit must not start a new frame.
         BREAK: begin
            cnt_d = '0;
            if (rx_s) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign busy      = (state_q != IDLE);

endmodule
